// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard for the 5-stage core: tracks in-flight destination tags,
// drives IF/ID freeze and ID->EXE bubble, registers EXE forward selects.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned FWD_EN   = 0,
  parameter int unsigned CNT_W    = 16,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_src1,
  input  logic [REG_AW-1:0] id_src2,
  input  logic              id_two_src,
  input  logic              id_wb_en,
  input  logic              id_mem_read,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              freeze,
  output logic              bubble,
  output logic [1:0]        fwd_sel1,
  output logic [1:0]        fwd_sel2,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Only the EXE and MEM tags are ever compared; the WB tag would never be read,
  // and only the EXE slot needs the load flag.
  logic              slot0V, slot0Wb, slot0Ld;
  logic [REG_AW-1:0] slot0Dest;
  logic              slot1V, slot1Wb;
  logic [REG_AW-1:0] slot1Dest;

  logic       m1s0, m1s1, m2s0, m2s1;
  logic       hz, advance, issue;
  logic [1:0] sel1Next, sel2Next;

  assign m1s0 = slot0V & slot0Wb & (slot0Dest == id_src1);
  assign m1s1 = slot1V & slot1Wb & (slot1Dest == id_src1);
  assign m2s0 = id_two_src & slot0V & slot0Wb & (slot0Dest == id_src2);
  assign m2s1 = id_two_src & slot1V & slot1Wb & (slot1Dest == id_src2);

  always_comb begin
    if (FWD_EN != 0) begin
      hz = id_valid & slot0Ld & (m1s0 | m2s0);
    end else begin
      hz = id_valid & (m1s0 | m1s1 | m2s0 | m2s1);
    end
  end

  assign advance = mem_ready;
  assign issue   = id_valid & ~hz & ~flush;
  assign freeze  = (hz & ~flush) | ~mem_ready;
  assign bubble  = advance & (hz | flush);

  // Newest producer wins: an EXE-slot ALU result beats the MEM-slot value.
  always_comb begin
    sel1Next = 2'd0;
    sel2Next = 2'd0;
    if (issue) begin
      if (m1s0 && !slot0Ld) sel1Next = 2'd1;
      else if (m1s1)        sel1Next = 2'd2;
      if (m2s0 && !slot0Ld) sel2Next = 2'd1;
      else if (m2s1)        sel2Next = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0V       <= 1'b0;
      slot0Wb      <= 1'b0;
      slot0Ld      <= 1'b0;
      slot0Dest    <= '0;
      slot1V       <= 1'b0;
      slot1Wb      <= 1'b0;
      slot1Dest    <= '0;
      fwd_sel1     <= 2'd0;
      fwd_sel2     <= 2'd0;
      stall_cycles <= '0;
    end else begin
      if (advance) begin
        slot1V    <= slot0V;
        slot1Wb   <= slot0Wb;
        slot1Dest <= slot0Dest;
        slot0V    <= issue;
        slot0Wb   <= issue & id_wb_en;
        slot0Ld   <= issue & id_mem_read;
        slot0Dest <= issue ? id_dest : '0;
        fwd_sel1  <= (FWD_EN != 0) ? sel1Next : 2'd0;
        fwd_sel2  <= (FWD_EN != 0) ? sel2Next : 2'd0;
      end
      if (freeze && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: freeze-only, forwarding and narrow-counter
// instances share one input set; each vector checks the instance it targets.
module tb_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_two_src, id_wb_en, id_mem_read, flush, mem_ready;
  logic [3:0] id_src1, id_src2, id_dest;

  logic        freeze0, bubble0, freeze1, bubble1, freeze2, bubble2;
  logic [1:0]  sel10, sel20, sel11, sel21, sel12, sel22;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NUM_REGS(16), .FWD_EN(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .flush(flush), .mem_ready(mem_ready), .freeze(freeze0),
    .bubble(bubble0), .fwd_sel1(sel10), .fwd_sel2(sel20), .stall_cycles(cnt0)
  );

  hazard_scoreboard #(.NUM_REGS(16), .FWD_EN(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .flush(flush), .mem_ready(mem_ready), .freeze(freeze1),
    .bubble(bubble1), .fwd_sel1(sel11), .fwd_sel2(sel21), .stall_cycles(cnt1)
  );

  hazard_scoreboard #(.NUM_REGS(16), .FWD_EN(0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_dest(id_dest), .flush(flush), .mem_ready(mem_ready), .freeze(freeze2),
    .bubble(bubble2), .fwd_sel1(sel12), .fwd_sel2(sel22), .stall_cycles(cnt2)
  );

  typedef struct {
    bit         rb;
    int         dut;
    logic       valid;
    logic [3:0] src1, src2;
    logic       two, wb, ld;
    logic [3:0] dest;
    logic       fl, rdy;
    int         eF, eB, eS1, eS2, eCnt;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(int rb, int dut, int valid, int s1, int s2, int two, int wb,
                              int ld, int dest, int fl, int rdy, int eF, int eB, int eS1,
                              int eS2, int eCnt);
    vec_t v;
    v.rb = bit'(rb); v.dut = dut; v.valid = 1'(valid);
    v.src1 = 4'(s1); v.src2 = 4'(s2); v.two = 1'(two); v.wb = 1'(wb); v.ld = 1'(ld);
    v.dest = 4'(dest); v.fl = 1'(fl); v.rdy = 1'(rdy);
    v.eF = eF; v.eB = eB; v.eS1 = eS1; v.eS2 = eS2; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic wb, input logic ld,
                       input logic [3:0] d, input logic fl, input logic rdy);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two; id_wb_en = wb;
    id_mem_read = ld; id_dest = d; flush = fl; mem_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int aF, aB, aS1, aS2, aC;
    rst = 1'b0;
    drive(1, 0, 0, 1, 1, 0, 0, 0, 1);
    #2;
    check("reset freeze0", int'(freeze0), 0);
    check("reset bubble1", int'(bubble1), 0);
    check("reset sel1", int'(sel11), 0);
    check("reset cnt2", int'(cnt2), 0);
    doReset();

    // T1 freeze-only RAW: two freeze+bubble cycles, then issue
    vec.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0, 2, 0, 1, 1, 1, 0, 0, 0));
    vec.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0, 2, 0, 1, 1, 1, 0, 0, 1));
    vec.push_back(mk(0, 0, 1, 1, 3, 1, 1, 0, 2, 0, 1, 0, 0, 0, 0, 2));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    // T2 forwarding: EXE result then WB value
    vec.push_back(mk(1, 1, 1, 2, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 5, 0, 1, 0, 0, 1, 0, 0));
    vec.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0));
    vec.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // T3 load-use: one freeze, then both sources from WB
    vec.push_back(mk(1, 1, 1, 3, 0, 0, 1, 1, 2, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 2, 2, 1, 1, 0, 6, 0, 1, 1, 1, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 2, 2, 1, 1, 0, 6, 0, 1, 0, 0, 0, 0, 1));
    vec.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 2, 1));
    // T5 flush beats RAW; killed r6 writer must not reach EXE slot
    vec.push_back(mk(1, 0, 1, 2, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 6, 1, 1, 0, 1, 0, 0, 0));
    vec.push_back(mk(0, 0, 1, 6, 0, 0, 1, 0, 7, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // T4 back-pressure: 3 held cycles, sel held, then issue with original tags
    vec.push_back(mk(1, 1, 1, 2, 3, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 4, 0, 1, 0, 0, 0, 0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 5, 0, 0, 1, 0, 1, 0, 0));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 5, 0, 0, 1, 0, 1, 0, 1));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 5, 0, 0, 1, 0, 1, 0, 2));
    vec.push_back(mk(0, 1, 1, 1, 0, 0, 1, 0, 5, 0, 1, 0, 0, 1, 0, 3));
    vec.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 3));

    foreach (vec[i]) begin
      if (vec[i].rb) doReset();
      drive(vec[i].valid, vec[i].src1, vec[i].src2, vec[i].two, vec[i].wb, vec[i].ld,
            vec[i].dest, vec[i].fl, vec[i].rdy);
      @(negedge clk);
      if (vec[i].dut == 0) begin
        aF = int'(freeze0); aB = int'(bubble0); aS1 = int'(sel10); aS2 = int'(sel20);
        aC = int'(cnt0);
      end else begin
        aF = int'(freeze1); aB = int'(bubble1); aS1 = int'(sel11); aS2 = int'(sel21);
        aC = int'(cnt1);
      end
      check($sformatf("vec%0d freeze", i), aF, vec[i].eF);
      check($sformatf("vec%0d bubble", i), aB, vec[i].eB);
      check($sformatf("vec%0d fwd_sel1", i), aS1, vec[i].eS1);
      check($sformatf("vec%0d fwd_sel2", i), aS2, vec[i].eS2);
      check($sformatf("vec%0d stall_cycles", i), aC, vec[i].eCnt);
      tick();
    end

    // T6 async reset while frozen on load-use with a non-zero forward select
    doReset();
    drive(1, 2, 3, 1, 1, 0, 1, 0, 1);
    tick();
    drive(1, 1, 0, 0, 1, 1, 2, 0, 1);
    tick();
    drive(1, 2, 2, 1, 1, 0, 6, 0, 0);
    tick();
    mem_ready = 1'b1;
    @(negedge clk);
    check("t6 pre freeze", int'(freeze1), 1);
    check("t6 pre bubble", int'(bubble1), 1);
    check("t6 pre fwd_sel1", int'(sel11), 1);
    check("t6 pre stall_cycles", int'(cnt1), 1);
    #2;
    rst = 1'b0;
    #1;
    check("t6 rst freeze", int'(freeze1), 0);
    check("t6 rst bubble", int'(bubble1), 0);
    check("t6 rst fwd_sel1", int'(sel11), 0);
    check("t6 rst stall_cycles", int'(cnt1), 0);
    tick();
    rst = 1'b1;

    // Narrow counter saturates; wide counter keeps counting
    doReset();
    mem_ready = 1'b0;
    repeat (3) tick();
    check("sat cnt2 at 3", int'(cnt2), 3);
    repeat (3) tick();
    check("sat cnt2 held", int'(cnt2), 3);
    check("wide cnt0 at 6", int'(cnt0), 6);
    check("stall bubble2", int'(bubble2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
